// File: rtl/detector_flancos_multi.sv
// Multi-channel edge detector.
// Each channel has a synchroniser, a consecutive-cycle debounce filter, a
// per-channel edge-mode tick and a sticky pending flag with its own clear.
module detector_flancos_multi #(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   nivel,
    input  logic [2*N-1:0] edge_sel,
    input  logic [N-1:0]   clr,
    output logic [N-1:0]   tick,
    output logic [N-1:0]   nivel_f,
    output logic [N-1:0]   pending,
    output logic           any_pending
);

    localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [N-1:0][SYNC_STAGES-1:0] sync_q;
    logic [N-1:0][CW-1:0]          cnt_q;
    logic [N-1:0][CW-1:0]          cnt_d;
    logic [N-1:0]                  sync_lvl;
    logic [N-1:0]                  commit;
    logic [N-1:0]                  nivel_f_d;
    logic [N-1:0]                  tick_d;
    logic [N-1:0]                  pending_d;

    // Synchroniser chains: bit 0 captures the raw level, top bit is the sync level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], nivel[i]};
            end
        end
    end

    // Debounce filter and edge qualification per channel
    always_comb begin
        sync_lvl  = '0;
        commit    = '0;
        cnt_d     = cnt_q;
        nivel_f_d = nivel_f;
        tick_d    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sync_lvl[i] = sync_q[i][SYNC_STAGES-1];
            if (sync_lvl[i] != nivel_f[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    commit[i]    = 1'b1;
                    cnt_d[i]     = '0;
                    nivel_f_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
            case (edge_sel[2*i +: 2])
                MODE_RISE: tick_d[i] = commit[i] & sync_lvl[i];
                MODE_FALL: tick_d[i] = commit[i] & ~sync_lvl[i];
                MODE_BOTH: tick_d[i] = commit[i];
                default:   tick_d[i] = 1'b0;
            endcase
        end
    end

    // Sticky flags: a new tick wins over a simultaneous clear
    always_comb begin
        pending_d = tick | (pending & ~clr);
    end

    // Filter state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            nivel_f <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            cnt_q   <= cnt_d;
            nivel_f <= nivel_f_d;
            tick    <= tick_d;
            pending <= pending_d;
        end
    end

    // Summary interrupt request
    always_comb begin
        any_pending = |pending;
    end

endmodule
